// File: rtl/seq_math_engine.sv
// Purpose: multi-cycle GCD (repeated subtraction) / factorial (repeated multiply) engine with overflow flag.
// Latency: GCD = number of subtract steps + 2 cycles from accept to out_valid; FACT(n) = n+2 cycles (shorter on overflow).
// Backpressure: one command in flight; in_ready low from accept until the cycle after the result handshake; result held while out_ready=0.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    command handshake; op (0=GCD(a,b), 1=FACT(a)), a, b operands
//   out_valid/out_ready  result handshake; result, ovf (factorial did not fit in N bits, result=0)
//   busy                 engine is running or holding an unconsumed result
//   cycles               (only with SEQ_MATH_CYCLE_CNT_EN) iteration-step count of the last command, saturating
//
// Optional feature macro: SEQ_MATH_CYCLE_CNT_EN adds the cycles output and its counter.

module seq_math_engine #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         busy
`ifdef SEQ_MATH_CYCLE_CNT_EN
  ,
  output logic [N-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_GCD  = 2'd1,
    RUN_FACT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   K_ONE = {{N{1'b0}}, 1'b1};

  state_t state_q, state_d;

  // x/y are shared between the two operations:
  //   GCD : x, y are the two running operands
  //   FACT: x is the accumulator, y holds n
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] y_q, y_d;
  logic [N:0]   k_q, k_d;   // one bit wider so k>n can still terminate when n is all-ones
  logic [N-1:0] result_d;
  logic         ovf_d;

  // Single shared subtractor: always subtracts the smaller from the larger.
  logic         x_gt_y;
  logic [N-1:0] diff;
  assign x_gt_y = (x_q > y_q);
  assign diff   = x_gt_y ? (x_q - y_q) : (y_q - x_q);

  // Single shared N x N multiplier. k[N] can only be set once k>n already holds,
  // so the low N bits of k are all the multiplier ever needs.
  logic [2*N-1:0] prod;
  assign prod = {{N{1'b0}}, x_q} * {{N{1'b0}}, k_q[N-1:0]};

  logic gcd_done, fact_done, prod_ovf, accept;
  assign gcd_done  = (x_q == '0) || (y_q == '0) || (x_q == y_q);
  assign fact_done = (k_q > {1'b0, y_q});
  assign prod_ovf  = |prod[2*N-1:N];
  assign accept    = (state_q == IDLE) && in_valid;

  // All handshake/status outputs decode the state register only, so there is
  // no combinational path from in_valid/out_ready to any output.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      result  <= result_d;
      ovf     <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    result_d = result;
    ovf_d    = ovf;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ovf_d = 1'b0;
          k_d   = K_ONE;
          if (op) begin
            x_d     = ONE_N;
            y_d     = a;
            state_d = RUN_FACT;
          end else begin
            x_d     = a;
            y_d     = b;
            state_d = RUN_GCD;
          end
        end
      end
      RUN_GCD: begin
        if (gcd_done) begin
          // Covers gcd(0,y)=y, gcd(x,0)=x, gcd(0,0)=0 and x==y.
          result_d = x_q | y_q;
          state_d  = DONE;
        end else if (x_gt_y) begin
          x_d = diff;
        end else begin
          y_d = diff;
        end
      end
      RUN_FACT: begin
        if (fact_done) begin
          result_d = x_q;
          state_d  = DONE;
        end else if (prod_ovf) begin
          ovf_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else begin
          x_d = prod[N-1:0];
          k_d = k_q + K_ONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEQ_MATH_CYCLE_CNT_EN
  // Counts the iteration steps (cycles that update x/y/k); the final cycle that
  // only detects completion is not counted.
  logic         step;
  logic [N-1:0] cyc_q;
  assign step = ((state_q == RUN_GCD)  && !gcd_done) ||
                ((state_q == RUN_FACT) && !fact_done && !prod_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (accept) begin
      cyc_q <= '0;
    end else if (step && (cyc_q != '1)) begin
      cyc_q <= cyc_q + ONE_N;
    end
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_seq_math_engine.sv
// Bench for seq_math_engine: directed cases with literal expectations plus
// randomized commands checked every cycle against a behavioural model.
module tb_seq_math_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf;
  logic        busy;
`ifdef SEQ_MATH_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif

  int checks = 0;
  int errors = 0;

  seq_math_engine #(.N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy)
`ifdef SEQ_MATH_CYCLE_CNT_EN
    ,
    .cycles    (cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] ref_gcd(input logic [15:0] p, input logic [15:0] q);
    logic [15:0] u, v, t;
    u = p;
    v = q;
    while (v != 16'd0) begin
      t = u % v;
      u = v;
      v = t;
    end
    return u;
  endfunction

  // Factorial with overflow; lat is the cycle index (accept cycle = 0) of first out_valid.
  task automatic ref_fact(input int n, output logic [15:0] r, output logic o, output int lat);
    longint acc;
    acc = 1;
    o   = 1'b0;
    lat = n + 2;
    for (int k = 1; k <= n; k++) begin
      acc = acc * k;
      if (acc > 65535) begin
        o   = 1'b1;
        lat = k + 1;
        break;
      end
    end
    r = o ? 16'd0 : acc[15:0];
  endtask

  // Model state: is a command outstanding, and what must it return.
  bit          engaged = 0;
  bit          seen = 0;
  int          cyc = 0;
  logic        exp_op;
  logic [15:0] exp_res;
  logic        exp_ovf;
  int          exp_lat;
  logic [15:0] last_res = 16'd0;
  logic        last_ovf = 1'b0;

  // Compare process: sample on the falling edge, then predict the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 0);
      engaged  = 0;
      seen     = 0;
      last_res = 16'd0;
      last_ovf = 1'b0;
    end else begin
      if (engaged) cyc++;
      chk("in_ready", in_ready, {31'd0, !engaged});
      chk("busy", busy, {31'd0, engaged});
      if (!engaged) begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_result", result, last_res);
        chk("idle_ovf", ovf, last_ovf);
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1;
          if (exp_op) chk("fact_latency", cyc, exp_lat);
        end
        chk("done_result", result, exp_res);
        chk("done_ovf", ovf, exp_ovf);
      end else begin
        chk("out_valid_dropped", {31'd0, seen}, 0);
        chk("run_result", result, last_res);
        chk("run_ovf", ovf, 0);
        if (cyc == 3000) begin
          checks++;
          errors++;
          $display("FAIL run_timeout actual=%0d cycles required=done", cyc);
        end
      end
      if (engaged && out_valid && out_ready) begin
        engaged  = 0;
        last_res = exp_res;
        last_ovf = exp_ovf;
      end else if (!engaged && in_valid) begin
        engaged = 1;
        seen    = 0;
        cyc     = 0;
        exp_op  = op;
        if (op) begin
          ref_fact(int'(a), exp_res, exp_ovf, exp_lat);
        end else begin
          exp_res = ref_gcd(a, b);
          exp_ovf = 1'b0;
          exp_lat = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic o, input logic [15:0] aa, input logic [15:0] bb);
    int t;
    t = 0;
    @(posedge clk); #1;
    op = o; a = aa; b = bb; in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns the cycle index (accept cycle = 0) at which out_valid was seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("result_timeout", out_valid, 1);
  endtask

  task automatic pass_handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int nstall;
    logic        r_op;
    logic [15:0] r_a, r_b;

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = 16'd0; b = 16'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(1'b0, 16'd48, 16'd18);
    wait_result(lat);
    chk("gcd_48_18", result, 6);
    chk("gcd_48_18_ovf", ovf, 0);
`ifdef SEQ_MATH_CYCLE_CNT_EN
    chk("gcd_48_18_cycles", cycles, 4);
`endif
    pass_handshake();

    issue(1'b0, 16'd0, 16'd7);
    wait_result(lat);
    chk("gcd_0_7", result, 7);
    chk("gcd_0_7_latency", lat, 2);
    pass_handshake();

    issue(1'b0, 16'd0, 16'd0);
    wait_result(lat);
    chk("gcd_0_0", result, 0);
    pass_handshake();

    issue(1'b1, 16'd8, 16'd0);
    wait_result(lat);
    chk("fact_8", result, 16'h9D80);
    chk("fact_8_ovf", ovf, 0);
    chk("fact_8_latency", lat, 10);
    pass_handshake();

    issue(1'b1, 16'd9, 16'd0);
    wait_result(lat);
    chk("fact_9_ovf", ovf, 1);
    chk("fact_9_result", result, 0);
    pass_handshake();

    issue(1'b1, 16'd0, 16'd0);
    wait_result(lat);
    chk("fact_0", result, 1);
    chk("fact_0_ovf", ovf, 0);
    pass_handshake();

    // Backpressure: result held, and a command offered during DONE is ignored.
    out_ready = 1'b0;
    issue(1'b0, 16'd48, 16'd18);
    wait_result(lat);
    in_valid = 1'b1; op = 1'b1; a = 16'd5; b = 16'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, 6);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_result", result, 6);

    // Reset in the middle of a factorial.
    issue(1'b1, 16'd8, 16'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_ovf", ovf, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(1'b0, 16'd12, 16'd8);
    wait_result(lat);
    chk("gcd_12_8", result, 4);
    pass_handshake();

    // Randomized commands with random result backpressure.
    for (int n = 0; n < 80; n++) begin
      r_op = 1'($urandom_range(0, 1));
      if (r_op) begin
        r_a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
        r_b = 16'($urandom);
      end else begin
        r_a = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
        r_b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
      end
      out_ready = 1'($urandom_range(0, 1));
      issue(r_op, r_a, r_b);
      wait_result(lat);
      if (!out_ready) begin
        nstall = $urandom_range(0, 3);
        repeat (nstall) begin
          @(posedge clk); #1;
        end
      end
      pass_handshake();
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
